// File: rtl/card_dealer.sv
// Card source: a rate-divided value selector plus a finite deck dealt without replacement.
// Define CARD_DEALER_LFSR_EN to drive the selector from an 8-bit LFSR instead of the divider.
module card_dealer #(
  parameter int VAL_W     = 4,
  parameter int MIN_VAL   = 1,
  parameter int MAX_VAL   = 11,
  parameter int COPIES    = 4,
  parameter int DIV_COUNT = 12499999,
  parameter int DIV_W     = 28,
  parameter int LEFT_W    = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              draw_req,
  input  logic              shuffle,
  output logic              busy,
  output logic              card_valid,
  output logic [VAL_W-1:0]  card_out,
  output logic              empty_err,
  output logic              deck_empty,
  output logic [LEFT_W-1:0] cards_left
);

  localparam int NUM_VALS = MAX_VAL - MIN_VAL + 1;
  localparam int IDX_W    = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1;
  localparam logic [VAL_W-1:0]  MIN_V    = VAL_W'(MIN_VAL);
  localparam logic [VAL_W-1:0]  MAX_V    = VAL_W'(MAX_VAL);
  localparam logic [3:0]        COPIES_V = 4'(COPIES);
  localparam logic [LEFT_W-1:0] TOTAL_V  = LEFT_W'(NUM_VALS * COPIES);

  typedef enum logic {IDLE, SEARCH} state_t;

  function automatic logic [VAL_W-1:0] wrap_inc(input logic [VAL_W-1:0] v);
    return (v == MAX_V) ? MIN_V : v + VAL_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] slot(input logic [VAL_W-1:0] v);
    logic [VAL_W-1:0] d;
    d = v - MIN_V;
    return IDX_W'(d);
  endfunction

  logic [VAL_W-1:0] sel;

`ifdef CARD_DEALER_LFSR_EN
  logic [7:0] lfsr;

  // Fibonacci form of x^8+x^6+x^5+x^4+1, stepped every clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign sel = MIN_V + VAL_W'(lfsr % 8'(NUM_VALS));
`else
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= DIV_W'(DIV_COUNT);
      sel     <= MIN_V;
    end else if (tick) begin
      div_cnt <= DIV_W'(DIV_COUNT);
      sel     <= wrap_inc(sel);
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end
`endif

  state_t           state, state_d;
  logic [VAL_W-1:0] idx, idx_d;
  logic [3:0]       remaining [NUM_VALS];
  logic             rem_hit;
  logic             take;
  logic             valid_d, empty_d;
  logic [VAL_W-1:0] out_d;

  assign rem_hit    = (remaining[slot(idx)] != 4'd0);
  assign busy       = (state == SEARCH);
  assign deck_empty = (cards_left == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // shuffle is checked first everywhere so it beats draw_req and aborts SEARCH
  always_comb begin
    state_d = state;
    idx_d   = idx;
    valid_d = 1'b0;
    empty_d = 1'b0;
    out_d   = card_out;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (!shuffle && draw_req) begin
          if (deck_empty) begin
            valid_d = 1'b1;
            empty_d = 1'b1;
            out_d   = '0;
          end else begin
            idx_d   = sel;
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (shuffle) begin
          state_d = IDLE;
        end else if (rem_hit) begin
          take    = 1'b1;
          valid_d = 1'b1;
          out_d   = idx;
          state_d = IDLE;
        end else begin
          idx_d = wrap_inc(idx);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx        <= MIN_V;
      card_valid <= 1'b0;
      empty_err  <= 1'b0;
      card_out   <= '0;
      cards_left <= TOTAL_V;
      for (int i = 0; i < NUM_VALS; i++) remaining[i] <= COPIES_V;
    end else begin
      idx        <= idx_d;
      card_valid <= valid_d;
      empty_err  <= empty_d;
      card_out   <= out_d;
      if (shuffle)   cards_left <= TOTAL_V;
      else if (take) cards_left <= cards_left - LEFT_W'(1);
      for (int i = 0; i < NUM_VALS; i++) begin
        if (shuffle)
          remaining[i] <= COPIES_V;
        else if (take && (slot(idx) == IDX_W'(i)))
          remaining[i] <= remaining[i] - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Randomized bench for card_dealer against a deck/selector model kept as plain counts.
module tb_card_dealer;

  localparam int MINV = 1;
  localparam int MAXV = 11;
  localparam int NV   = MAXV - MINV + 1;
  localparam int CP   = 4;
  localparam int DIV  = 3;

  logic       clock = 1'b0;
  logic       reset, draw_req, shuffle;
  logic       busy, card_valid, empty_err, deck_empty;
  logic [3:0] card_out;
  logic [5:0] cards_left;

  always #5 clock = ~clock;

  card_dealer #(.DIV_COUNT(DIV)) dut (
    .clock(clock), .reset(reset), .draw_req(draw_req), .shuffle(shuffle),
    .busy(busy), .card_valid(card_valid), .card_out(card_out),
    .empty_err(empty_err), .deck_empty(deck_empty), .cards_left(cards_left)
  );

  int vectors = 0;
  int miscompares = 0;
  int n_edges;
  int rem [MAXV+1];
  int total;

  // clock edges since reset release; the selector is a pure function of it
  always @(posedge clock or posedge reset)
    if (reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sel_now();
    return MINV + (n_edges / (DIV + 1)) % NV;
  endfunction

  task automatic model_refill();
    for (int v = MINV; v <= MAXV; v++) rem[v] = CP;
    total = NV * CP;
  endtask

  task automatic draw();
    int s, k, v, cyc;
    s = sel_now();
    draw_req = 1'b1;
    @(negedge clock);
    draw_req = 1'b0;
    if (total == 0) begin
      chk("empty_valid", card_valid, 1);
      chk("empty_err", empty_err, 1);
      chk("empty_out", card_out, 0);
      chk("empty_busy", busy, 0);
      @(negedge clock);
      chk("empty_pulse", card_valid, 0);
    end else begin
      k = 0; v = 0;
      for (int j = 0; j < NV; j++) begin
        int c;
        c = MINV + ((s - MINV + j) % NV);
        if (k == 0 && rem[c] > 0) begin k = j + 1; v = c; end
      end
      rem[v]--; total--;
      chk("busy", busy, 1);
      chk("valid_early", card_valid, 0);
      cyc = 1;
      while (!card_valid && cyc < NV + 4) begin
        @(negedge clock);
        cyc++;
      end
      chk("latency", cyc - 1, k);
      chk("card", card_out, v);
      chk("left", cards_left, total);
      chk("deck_empty", deck_empty, (total == 0));
      chk("err_low", empty_err, 0);
      @(negedge clock);
      chk("pulse", card_valid, 0);
      chk("idle", busy, 0);
      chk("hold", card_out, v);
    end
  endtask

  task automatic shuffle_with_draw();
    shuffle = 1'b1; draw_req = 1'b1;
    @(negedge clock);
    shuffle = 1'b0; draw_req = 1'b0;
    model_refill();
    chk("shd_valid", card_valid, 0);
    chk("shd_busy", busy, 0);
    chk("shd_left", cards_left, total);
    @(negedge clock);
    chk("shd_valid2", card_valid, 0);
  endtask

  task automatic shuffle_in_search();
    draw_req = 1'b1;
    @(negedge clock);
    draw_req = 1'b0;
    chk("shs_busy_pre", busy, 1);
    shuffle = 1'b1;
    @(negedge clock);
    shuffle = 1'b0;
    model_refill();
    chk("shs_valid", card_valid, 0);
    chk("shs_busy", busy, 0);
    chk("shs_left", cards_left, total);
    @(negedge clock);
    chk("shs_valid2", card_valid, 0);
  endtask

  task automatic reset_in_search();
    draw_req = 1'b1;
    @(negedge clock);
    draw_req = 1'b0;
    chk("rst_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    model_refill();
    chk("rst_busy", busy, 0);
    chk("rst_valid", card_valid, 0);
    chk("rst_out", card_out, 0);
    chk("rst_err", empty_err, 0);
    chk("rst_left", cards_left, total);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1; draw_req = 1'b0; shuffle = 1'b0;
    model_refill();
    repeat (2) @(negedge clock);
    chk("r_busy", busy, 0);
    chk("r_valid", card_valid, 0);
    chk("r_out", card_out, 0);
    chk("r_err", empty_err, 0);
    chk("r_left", cards_left, 44);
    chk("r_empty", deck_empty, 0);
    reset = 1'b0;

    for (int i = 0; i < 48; i++) begin
      @(negedge clock);
      chk("idle_valid", card_valid, 0);
      chk("idle_left", cards_left, 44);
    end

    // back-to-back burst, then run the deck dry and draw past empty
    repeat (5) draw();
    while (total > 0) draw();
    chk("dry_flag", deck_empty, 1);
    draw();
    draw();
    shuffle_with_draw();
    draw();
    shuffle_in_search();
    draw();
    reset_in_search();

    for (int it = 0; it < 250; it++) begin
      repeat ($urandom_range(0, 5)) @(negedge clock);
      r = $urandom_range(0, 99);
      if (r < 85 || total == 0) draw();
      else if (r < 92) shuffle_in_search();
      else if (r < 97) shuffle_with_draw();
      else reset_in_search();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
